// File: rtl/input_pixel_queue_if.sv
// Pixel stream and index-queue signals between the pixel source, the
// input queue and the Layer 1 controller.
interface input_pixel_queue_if #(
    parameter int unsigned PIXEL_BITS  = 8,
    parameter int unsigned INDEX_WIDTH = 10
);
    logic [PIXEL_BITS-1:0]  pixelIn;
    logic                   pixelValid;
    logic                   pixelReady;
    logic                   dequeue;
    logic [INDEX_WIDTH-1:0] queueOut;
    logic                   queueEmpty;
    logic                   inputsReady;
    logic [INDEX_WIDTH-1:0] activeCount;

    modport master (
        output pixelIn, pixelValid, dequeue,
        input  pixelReady, queueOut, queueEmpty, inputsReady, activeCount
    );

    modport slave (
        input  pixelIn, pixelValid, dequeue,
        output pixelReady, queueOut, queueEmpty, inputsReady, activeCount
    );
endinterface

// File: rtl/input_pixel_queue.sv
// Binarizes a raster-ordered image and queues the indices of active pixels
// in a show-ahead FIFO for the Layer 1 controller.
module input_pixel_queue #(
    parameter int unsigned NUM_PIXELS  = 784,
    parameter int unsigned PIXEL_BITS  = 8,
    parameter int unsigned THRESHOLD   = 128,
    parameter int unsigned INDEX_WIDTH = 10,
    parameter int unsigned QUEUE_DEPTH = 1024,
    parameter int unsigned DRAIN_HOLD  = 2
) (
    input logic               clk,
    input logic               reset,
    input_pixel_queue_if.slave bus
);
    localparam int unsigned PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned HOLD_W = (DRAIN_HOLD > 1) ? $clog2(DRAIN_HOLD) : 1;

    if (QUEUE_DEPTH < NUM_PIXELS) begin : g_depth_check
        $error("QUEUE_DEPTH must be at least NUM_PIXELS");
    end
    if ((2 ** INDEX_WIDTH) < NUM_PIXELS) begin : g_index_check
        $error("INDEX_WIDTH too narrow for NUM_PIXELS");
    end
    if (DRAIN_HOLD < 1) begin : g_hold_check
        $error("DRAIN_HOLD must be at least 1");
    end

    typedef enum logic [1:0] {
        LOAD,
        READY,
        HOLD
    } state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] pix_idx;
    logic [INDEX_WIDTH-1:0] active_cnt;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   inputs_ready;
    logic [INDEX_WIDTH-1:0] mem [QUEUE_DEPTH];

    logic transfer;
    logic active;
    logic push;
    logic pop;
    logic last;
    logic empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty    = (count == '0);
        transfer = bus.pixelValid && (state == LOAD);
        active   = (32'(bus.pixelIn) >= THRESHOLD);
        push     = transfer && active;
        pop      = (state == READY) && bus.dequeue && !empty;
        last     = (pix_idx == INDEX_WIDTH'(NUM_PIXELS - 1));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pix_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD;
            pix_idx      <= '0;
            active_cnt   <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            hold_cnt     <= '0;
            inputs_ready <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (transfer) begin
                        pix_idx <= last ? '0 : pix_idx + 1'b1;
                        if (push) begin
                            wr_ptr     <= ptr_inc(wr_ptr);
                            active_cnt <= active_cnt + 1'b1;
                        end
                        if (last) begin
                            inputs_ready <= 1'b1;
                            // An image with no active pixels has nothing to drain.
                            if (empty && !push) begin
                                state    <= HOLD;
                                hold_cnt <= HOLD_W'(DRAIN_HOLD - 1);
                            end else begin
                                state <= READY;
                            end
                        end
                    end
                end
                READY: begin
                    if (pop) begin
                        rd_ptr <= ptr_inc(rd_ptr);
                    end
                    if (empty || (pop && count == CNT_W'(1))) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_W'(DRAIN_HOLD - 1);
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state        <= LOAD;
                        inputs_ready <= 1'b0;
                        active_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state        <= LOAD;
                    inputs_ready <= 1'b0;
                end
            endcase

            if (push) begin
                count <= count + 1'b1;
            end else if (pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign bus.pixelReady  = (state == LOAD);
    assign bus.queueEmpty  = empty;
    assign bus.queueOut    = empty ? '0 : mem[rd_ptr];
    assign bus.inputsReady = inputs_ready;
    assign bus.activeCount = active_cnt;

endmodule

// File: tb/tb_input_pixel_queue.sv
// Directed bench for input_pixel_queue: threshold, ordering, drain hold,
// pointer wrap, reset abort and ignored dequeue/pixel traffic.
module tb_input_pixel_queue;
    localparam int NPIX = 784;

    logic clk = 1'b0;
    logic reset;

    input_pixel_queue_if #(.PIXEL_BITS(8), .INDEX_WIDTH(10)) bus ();

    input_pixel_queue #(
        .NUM_PIXELS (784),
        .PIXEL_BITS (8),
        .THRESHOLD  (128),
        .INDEX_WIDTH(10),
        .QUEUE_DEPTH(1024),
        .DRAIN_HOLD (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  img [NPIX];
    int          exp_q [$];
    int          exp_active;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
    endtask

    // Streams img[] and builds the expected index queue from the 128 threshold.
    task automatic send_image(input string tag);
        exp_active = 0;
        for (int i = 0; i < NPIX; i++) begin
            bus.pixelIn    = img[i];
            bus.pixelValid = 1'b1;
            if (i == 0) check({tag, "_ready_first"}, 32'(bus.pixelReady), 1);
            if (i == 400) check({tag, "_ir_midload"}, 32'(bus.inputsReady), 0);
            if (img[i] >= 8'd128) begin
                exp_q.push_back(i);
                exp_active++;
            end
            tick();
        end
        bus.pixelValid = 1'b0;
        check({tag, "_ir_after_last"}, 32'(bus.inputsReady), 1);
        check({tag, "_ready_low"}, 32'(bus.pixelReady), 0);
        check({tag, "_active"}, 32'(bus.activeCount), 32'(exp_active));
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (exp_q.size() > 0) begin
            if (k > 0) tick();
            check({tag, "_head"}, 32'(bus.queueOut), 32'(exp_q.pop_front()));
            bus.dequeue = 1'b1;
            tick();
            bus.dequeue = 1'b0;
            k++;
        end
    endtask

    // Runs from one cycle after the queue went empty through the return to LOAD.
    task automatic hold_tail(input string tag, input bit hold_deq);
        check({tag, "_empty"}, 32'(bus.queueEmpty), 1);
        check({tag, "_qout0"}, 32'(bus.queueOut), 0);
        check({tag, "_ir_hold1"}, 32'(bus.inputsReady), 1);
        check({tag, "_pr_hold1"}, 32'(bus.pixelReady), 0);
        if (hold_deq) bus.dequeue = 1'b1;
        tick();
        check({tag, "_ir_hold2"}, 32'(bus.inputsReady), 1);
        check({tag, "_pr_hold2"}, 32'(bus.pixelReady), 0);
        check({tag, "_empty_hold2"}, 32'(bus.queueEmpty), 1);
        tick();
        bus.dequeue = 1'b0;
        check({tag, "_ir_fall"}, 32'(bus.inputsReady), 0);
        check({tag, "_pr_back"}, 32'(bus.pixelReady), 1);
        check({tag, "_active_clr"}, 32'(bus.activeCount), 0);
        check({tag, "_empty_load"}, 32'(bus.queueEmpty), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.pixelIn    = 8'd0;
        bus.pixelValid = 1'b0;
        bus.dequeue    = 1'b0;
        tick();
        tick();
        check("rst_pixelReady", 32'(bus.pixelReady), 1);
        check("rst_queueEmpty", 32'(bus.queueEmpty), 1);
        check("rst_queueOut", 32'(bus.queueOut), 0);
        check("rst_inputsReady", 32'(bus.inputsReady), 0);
        check("rst_activeCount", 32'(bus.activeCount), 0);
        reset = 1'b0;
        tick();

        // 1: all-zero image
        clear_img();
        send_image("t1");
        check("t1_empty_ready", 32'(bus.queueEmpty), 1);
        hold_tail("t1", 1'b0);

        // 2: three active pixels including the last index
        clear_img();
        img[5] = 8'd200; img[100] = 8'd200; img[783] = 8'd200;
        send_image("t2");
        check("t2_active3", 32'(bus.activeCount), 3);
        check("t2_head5", 32'(bus.queueOut), 5);
        drain("t2");
        hold_tail("t2", 1'b0);

        // 3: threshold boundary
        clear_img();
        img[0] = 8'd127; img[1] = 8'd128;
        send_image("t3");
        check("t3_active1", 32'(bus.activeCount), 1);
        check("t3_head1", 32'(bus.queueOut), 1);
        drain("t3");
        hold_tail("t3", 1'b0);

        // 4: two 600-pixel images push both pointers past 1023
        clear_img();
        for (int i = 0; i < NPIX; i++) img[i] = (i < 600) ? 8'(128 + i % 128) : 8'(i % 128);
        send_image("t4a");
        check("t4a_active600", 32'(bus.activeCount), 600);
        drain("t4a");
        hold_tail("t4a", 1'b0);
        for (int i = 0; i < NPIX; i++) img[i] = (i >= 184) ? 8'(255 - i % 128) : 8'(i % 128);
        send_image("t4b");
        check("t4b_active600", 32'(bus.activeCount), 600);
        check("t4b_head184", 32'(bus.queueOut), 184);
        drain("t4b");
        hold_tail("t4b", 1'b0);

        // 5: reset after 300 pixels discards the partial image
        for (int i = 0; i < 300; i++) begin
            bus.pixelIn    = 8'd200;
            bus.pixelValid = 1'b1;
            tick();
        end
        bus.pixelValid = 1'b0;
        check("t5_partial_active", 32'(bus.activeCount), 300);
        reset = 1'b1;
        #2;
        check("t5_rst_empty", 32'(bus.queueEmpty), 1);
        check("t5_rst_active", 32'(bus.activeCount), 0);
        check("t5_rst_ir", 32'(bus.inputsReady), 0);
        check("t5_rst_pr", 32'(bus.pixelReady), 1);
        tick();
        reset = 1'b0;
        tick();
        clear_img();
        img[0] = 8'd255; img[10] = 8'd130; img[783] = 8'd128;
        send_image("t5");
        check("t5_head0", 32'(bus.queueOut), 0);
        drain("t5");
        hold_tail("t5", 1'b0);

        // 6: pixel held valid through READY/HOLD, dequeues while empty and in LOAD
        clear_img();
        img[2] = 8'd200; img[50] = 8'd129;
        send_image("t6");
        bus.pixelIn    = 8'd255;
        bus.pixelValid = 1'b1;
        tick();
        check("t6_pr_ready", 32'(bus.pixelReady), 0);
        check("t6_active_held", 32'(bus.activeCount), 2);
        drain("t6");
        hold_tail("t6", 1'b1);
        bus.pixelValid = 1'b0;
        clear_img();
        img[783] = 8'd250;
        bus.dequeue = 1'b1;
        send_image("t6b");
        bus.dequeue = 1'b0;
        check("t6b_head783", 32'(bus.queueOut), 783);
        check("t6b_notempty", 32'(bus.queueEmpty), 0);
        drain("t6b");
        hold_tail("t6b", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/input_pixel_queue.md
Name: input_pixel_queue

Overview:
- Input stage of the neural network pipeline, directly upstream of the Layer 1 controller.
- Accepts one raster-ordered image as a stream of grey-scale pixels and binarizes each pixel against a threshold.
- Enqueues the 10-bit index of every active pixel into a show-ahead FIFO.
- Layer 1 drains the FIFO via queueOut/queueEmpty/dequeue while inputsReady is high.

Parameters:
NUM_PIXELS, 784, pixels per image (28x28)
PIXEL_BITS, 8, width of incoming pixel value
THRESHOLD, 128, pixel is active when value >= THRESHOLD (unsigned compare)
INDEX_WIDTH, 10, width of pixel index; 2**INDEX_WIDTH >= NUM_PIXELS
QUEUE_DEPTH, 1024, FIFO entries; must be >= NUM_PIXELS (elaboration-time check, so overflow is impossible)
DRAIN_HOLD, 2, cycles inputsReady stays high after the queue goes empty

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
pixelIn  input  PIXEL_BITS  current pixel value
pixelValid  input  1  pixelIn is valid
pixelReady  output  1  block accepts a pixel this cycle
dequeue  input  1  pop the FIFO head (from Layer 1)
queueOut  output  INDEX_WIDTH  FIFO head index (show-ahead)
queueEmpty  output  1  FIFO holds no entries
inputsReady  output  1  a full image is loaded and available to Layer 1
activeCount  output  INDEX_WIDTH  number of active pixels in the current image

Behaviour:
- Reset (asynchronous, active-high, clock clk):
  - FSM goes to LOAD; FIFO pointers and count clear; pixel index counter = 0.
  - Output reset values: pixelReady=1 (combinational from state), queueEmpty=1, queueOut=0, inputsReady=0, activeCount=0.
- Pixel transfer occurs on a rising edge with pixelValid && pixelReady.
- FSM states:
  - LOAD: pixelReady=1, inputsReady=0.
    - Each transfer: if pixelIn >= THRESHOLD, write the current index to the FIFO tail and increment activeCount.
    - Index counter increments on every transfer.
    - On the transfer at index NUM_PIXELS-1: counter wraps to 0, next state READY.
  - READY: pixelReady=0, inputsReady=1.
    - dequeue sampled high while not empty pops one entry; queueOut shows the new head on the next cycle.
    - When the FIFO becomes empty (including an image with zero active pixels), go to HOLD with hold counter = DRAIN_HOLD-1.
  - HOLD: inputsReady=1, queueEmpty=1.
    - Hold counter decrements each cycle; at 0, go to LOAD.
    - On entering LOAD: inputsReady=0, activeCount clears to 0.
- FIFO:
  - Circular buffer of QUEUE_DEPTH entries; read and write pointers wrap modulo QUEUE_DEPTH.
  - queueEmpty = (count==0). queueOut = mem[rd_ptr] when not empty, 0 when empty.
  - Latency from enqueue to visible at queueOut when the FIFO was empty: 1 cycle.
- Boundary conditions:
  - dequeue while empty: ignored; pointers unchanged.
  - dequeue in LOAD: ignored.
  - Write and pop never coincide, because LOAD only writes and READY only pops.
  - Pointers persist across images; the wrap-around past QUEUE_DEPTH-1 must be correct.
  - pixelValid in READY/HOLD: not accepted (pixelReady=0); the upstream source holds the pixel.
  - Reset mid-LOAD or mid-READY: partial image discarded; FIFO cleared; next pixel accepted is index 0.
  - Index NUM_PIXELS-1 active: enqueued before the transition to READY; inputsReady asserts the cycle after that transfer.

Test Plan:
1. Reset, then stream 784 pixels, all value 0 -> queueEmpty stays 1; inputsReady high exactly DRAIN_HOLD=2 cycles, then 0; activeCount=0; pixelReady returns 1.
2. Pixels 5, 100 and 783 = 200, others 0 -> inputsReady=1 the cycle after pixel 783; activeCount=3; dequeue pulses yield queueOut 5, 100, 783 in order; after the 3rd pop queueEmpty=1, inputsReady falls 2 cycles later.
3. Pixel values 127 and 128 at indices 0 and 1 -> only index 1 is enqueued (threshold boundary).
4. Images with 600 active pixels, fully drained, repeated twice -> read/write pointers wrap past 1023; all 1200 indices are returned correctly in order.
5. Reset asserted mid-LOAD after 300 pixels -> queueEmpty=1, activeCount=0, inputsReady=0; a new 784-pixel image then loads with indices starting at 0.
6. Extra dequeue pulses while empty, and pixelValid=1 held during READY -> no pointer change, no pixel accepted; pixelReady=0 until HOLD completes.
